// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: stores {bi, fe, pe, data} per character,
// presents the head first-word-fall-through and derives the LSR overrun/error/trigger flags.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pe_in,
    input  logic                     fe_in,
    input  logic                     bi_in,
    input  logic                     pop,
    input  logic                     lsr_rd,
    input  logic                     fifo_en,
    input  logic                     clr,
    input  logic [1:0]               trig_lvl,
    output logic [WIDTH-1:0]         dout,
    output logic                     pe_out,
    output logic                     fe_out,
    output logic                     bi_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     err_in_fifo,
    output logic                     trig_hit
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned EW    = WIDTH + 3;
    localparam int unsigned LVL4  = (DEPTH < 4)  ? DEPTH : 4;
    localparam int unsigned LVL8  = (DEPTH < 8)  ? DEPTH : 8;
    localparam int unsigned LVL14 = (DEPTH < 14) ? DEPTH : 14;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] cap;
    logic [CW-1:0] lvl;
    logic [EW-1:0] head;
    logic          push_ok;
    logic          pop_ok;
    logic          push_err;
    logic          head_err;

    always_comb begin
        cap      = fifo_en ? CW'(DEPTH) : CW'(1);
        empty    = (cnt == '0);
        // count may exceed cap after fifo_en drops, so full is a >= test
        full     = (cnt >= cap);
        pop_ok   = pop & ~empty;
        // a simultaneous pop frees a slot, so a push into a full FIFO still lands
        push_ok  = push & (~full | pop_ok);
        head     = mem[rptr];
        head_err = |head[EW-1:WIDTH];
        push_err = pe_in | fe_in | bi_in;
    end

    always_comb begin
        lvl = CW'(1);
        if (fifo_en) begin
            unique case (trig_lvl)
                2'b00: lvl = CW'(1);
                2'b01: lvl = CW'(LVL4);
                2'b10: lvl = CW'(LVL8);
                2'b11: lvl = CW'(LVL14);
            endcase
        end
        trig_hit = (cnt >= lvl);
    end

    always_comb begin
        dout        = '0;
        pe_out      = 1'b0;
        fe_out      = 1'b0;
        bi_out      = 1'b0;
        if (!empty) begin
            dout   = head[WIDTH-1:0];
            pe_out = head[WIDTH];
            fe_out = head[WIDTH+1];
            bi_out = head[WIDTH+2];
        end
        count       = cnt;
        err_in_fifo = (err_cnt != '0);
    end

    always_ff @(posedge clk) begin
        if (rst && !clr && push_ok)
            mem[wptr] <= {bi_in, fe_in, pe_in, din};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            err_cnt <= '0;
            overrun <= 1'b0;
        end else begin
            if (clr) begin
                wptr    <= '0;
                rptr    <= '0;
                cnt     <= '0;
                err_cnt <= '0;
            end else begin
                if (push_ok)
                    wptr <= wptr + AW'(1);
                if (pop_ok)
                    rptr <= rptr + AW'(1);
                cnt     <= cnt + CW'(push_ok) - CW'(pop_ok);
                err_cnt <= err_cnt + CW'(push_ok & push_err) - CW'(pop_ok & head_err);
            end
            if (!clr && push && !push_ok)
                overrun <= 1'b1;
            else if (lsr_rd)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized scoreboard bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             pe_in = 1'b0;
    logic             fe_in = 1'b0;
    logic             bi_in = 1'b0;
    logic             pop = 1'b0;
    logic             lsr_rd = 1'b0;
    logic             fifo_en = 1'b1;
    logic             clr = 1'b0;
    logic [1:0]       trig_lvl = 2'b00;
    logic [WIDTH-1:0] dout;
    logic             pe_out;
    logic             fe_out;
    logic             bi_out;
    logic             empty;
    logic             full;
    logic [4:0]       count;
    logic             overrun;
    logic             err_in_fifo;
    logic             trig_hit;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .push(push), .din(din), .pe_in(pe_in), .fe_in(fe_in),
        .bi_in(bi_in), .pop(pop), .lsr_rd(lsr_rd), .fifo_en(fifo_en), .clr(clr),
        .trig_lvl(trig_lvl), .dout(dout), .pe_out(pe_out), .fe_out(fe_out),
        .bi_out(bi_out), .empty(empty), .full(full), .count(count), .overrun(overrun),
        .err_in_fifo(err_in_fifo), .trig_hit(trig_hit)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err = 0;
    bit   mon_en = 0;
    bit   m_ovr = 0;
    logic [10:0] m_q[$];
    logic [10:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned exp_lvl();
        int unsigned l;
        if (!fifo_en) return 1;
        case (trig_lvl)
            2'b00: l = 1;
            2'b01: l = 4;
            2'b10: l = 8;
            default: l = 14;
        endcase
        return (l > DEPTH) ? DEPTH : l;
    endfunction

    function automatic bit exp_err();
        foreach (m_q[i]) if (m_q[i][10:8] != 3'b000) return 1;
        return 0;
    endfunction

    // Monitor: status against the model every cycle, read data against the scoreboard.
    always @(negedge clk) begin : monitor
        logic [10:0] h;
        logic [10:0] e;
        int unsigned cap;
        if (mon_en) begin
            cap = fifo_en ? DEPTH : 1;
            h = (m_q.size() > 0) ? m_q[0] : 11'h0;
            chk("count", 32'(count), 32'(m_q.size()));
            chk("empty", 32'(empty), 32'(m_q.size() == 0));
            chk("full", 32'(full), 32'(m_q.size() >= cap));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("err_in_fifo", 32'(err_in_fifo), 32'(exp_err()));
            chk("trig_hit", 32'(trig_hit), 32'(m_q.size() >= exp_lvl()));
            chk("head", 32'({bi_out, fe_out, pe_out, dout}), 32'(h));
            if (pop && !clr && !empty) begin
                if (exp_q.size() == 0) begin
                    chk("rd_unexpected", 32'({bi_out, fe_out, pe_out, dout}), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", 32'({bi_out, fe_out, pe_out, dout}), 32'(e));
                end
            end
        end
    end

    // fl = {bi, fe, pe}
    task automatic step(input bit ps, input logic [7:0] d, input logic [2:0] fl,
                        input bit pp, input bit lr, input bit cl);
        int unsigned cap;
        bit can_pop;
        bit can_push;
        push = ps; din = d; {bi_in, fe_in, pe_in} = fl;
        pop = pp; lsr_rd = lr; clr = cl;
        cap = fifo_en ? DEPTH : 1;
        can_pop  = !cl && pp && (m_q.size() > 0);
        can_push = !cl && ps && ((m_q.size() < cap) || can_pop);
        if (can_pop) exp_q.push_back(m_q[0]);
        @(posedge clk);
        #1;
        if (cl) begin
            m_q.delete();
        end else begin
            if (can_pop) void'(m_q.pop_front());
            if (can_push) m_q.push_back({fl, d});
        end
        if (!cl && ps && !can_push) m_ovr = 1;
        else if (lr) m_ovr = 0;
        push = 0; pop = 0; lsr_rd = 0; clr = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_trig", 32'(trig_hit), 32'd0);
        chk("rst_err", 32'(err_in_fifo), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_dout", 32'({bi_out, fe_out, pe_out, dout}), 32'd0);
        rst = 1;
        mon_en = 1;

        // Single entry with parity error
        step(1, 8'h45, 3'b001, 0, 0, 0);
        chk("t1_dout", 32'(dout), 32'h45);
        chk("t1_pe", 32'(pe_out), 32'd1);
        chk("t1_err", 32'(err_in_fifo), 32'd1);
        step(0, 8'h00, 3'b000, 1, 0, 0);
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_err0", 32'(err_in_fifo), 32'd0);
        chk("t1_dout0", 32'(dout), 32'd0);

        // Fill to trigger and capacity, then overflow
        trig_lvl = 2'b10;
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 3'b000, 0, 0, 0);
            chk("t2_trig", 32'(trig_hit), 32'(i + 1 >= 8));
        end
        chk("t2_full", 32'(full), 32'd1);
        step(1, 8'hAA, 3'b000, 0, 0, 0);
        chk("t2_ovr", 32'(overrun), 32'd1);
        chk("t2_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_order", 32'(dout), 32'(i));
            step(0, 8'h00, 3'b000, 1, 0, 0);
        end

        // Overrun clear, and set winning over a coincident clear
        step(0, 8'h00, 3'b000, 0, 1, 0);
        chk("t3_clr", 32'(overrun), 32'd0);
        for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 3'b000, 0, 0, 0);
        step(1, 8'hBB, 3'b000, 0, 1, 0);
        chk("t3_setwins", 32'(overrun), 32'd1);
        step(0, 8'h00, 3'b000, 0, 1, 0);

        // Push and pop together on a full and on an empty FIFO
        step(1, 8'h55, 3'b000, 1, 0, 0);
        chk("t4_count", 32'(count), 32'd16);
        chk("t4_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("t4_last", 32'(dout), 32'h55);
            step(0, 8'h00, 3'b000, 1, 0, 0);
        end
        step(1, 8'h3C, 3'b000, 1, 0, 0);
        chk("t4_cnt1", 32'(count), 32'd1);
        chk("t4_dout", 32'(dout), 32'h3C);
        step(0, 8'h00, 3'b000, 1, 0, 0);

        // Single holding register mode
        fifo_en = 0;
        step(1, 8'h11, 3'b000, 0, 0, 0);
        chk("t5_full", 32'(full), 32'd1);
        chk("t5_trig", 32'(trig_hit), 32'd1);
        step(1, 8'h22, 3'b000, 0, 0, 0);
        chk("t5_ovr", 32'(overrun), 32'd1);
        chk("t5_dout", 32'(dout), 32'h11);
        step(0, 8'h00, 3'b000, 1, 0, 0);
        fifo_en = 1;

        // Flush with a coincident push; overrun left set
        for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), (i == 2) ? 3'b010 : 3'b000, 0, 0, 0);
        step(1, 8'h77, 3'b000, 0, 0, 1);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_err", 32'(err_in_fifo), 32'd0);
        chk("t6_ovr", 32'(overrun), 32'd1);
        step(0, 8'h00, 3'b000, 0, 1, 0);

        // Pointer wrap with interleaved push/pop
        for (int i = 0; i < 40; i++)
            step(1, 8'($urandom), 3'($urandom_range(0, 3) == 0 ? $urandom : 0), i > 0, 0, 0);
        step(0, 8'h00, 3'b000, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) fifo_en = ~fifo_en;
            if ($urandom_range(0, 49) == 0) trig_lvl = 2'($urandom);
            step($urandom_range(0, 99) < 55, 8'($urandom),
                 3'($urandom_range(0, 4) == 0 ? $urandom : 0),
                 $urandom_range(0, 99) < 45, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 199) == 0);
        end
        fifo_en = 1;
        for (int i = 0; i < DEPTH + 1; i++) step(0, 8'h00, 3'b000, 1, 1, 0);
        @(negedge clk);
        mon_en = 0;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
